// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiplier that drives the 16-bit ALU port.
// Holds the ALU opcode constants and the sequencer state encoding.
package alu_mul_sequencer_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TEST  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned multiplier (low WIDTH bits of a*b) that borrows the external ALU
// for every bit-test and every addition; shifting and counting stay local.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mplier_shr;

    assign mplier_shr = mplier >> 1;

    // NOTE: all state below is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= a;
                        mplier <= b;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= TEST;
                    end
                end
                // alu_zero is high when the ALU result is non-zero, i.e. the tested bit is set
                TEST: state <= alu_zero ? ADD : SHIFT;
                ADD: begin
                    acc   <= alu_out;
                    state <= SHIFT;
                end
                SHIFT: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier_shr;
                    cnt    <= cnt + 1'b1;
                    if (mplier_shr == '0 || cnt == CW'(WIDTH - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= TEST;
                    end
                end
                DONE: begin
                    product <= acc;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        case (state)
            TEST: begin
                alu_a  = mplier;
                alu_b  = WIDTH'(1);
                alu_op = ALU_AND;
            end
            ADD: begin
                alu_a  = acc;
                alu_b  = mcand;
                alu_op = ALU_ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: behavioural ALU beside the sequencer, expected ALU traffic and
// products derived from the multiplier bits of b, directed plus randomized operations.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done;
    logic [15:0] product, alu_a, alu_b, alu_out;
    logic [1:0]  alu_op;
    logic        alu_zero;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] prev_product = '0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] x;
        logic [15:0] y;
    } drive_t;

    alu_mul_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // Behavioural 16-bit ALU; its flag reads 1 when the result is non-zero.
    always_comb begin
        case (alu_op)
            2'b00:   alu_out = alu_a + alu_b;
            2'b01:   alu_out = alu_a - alu_b;
            2'b10:   alu_out = alu_a & alu_b;
            default: alu_out = ~alu_a;
        endcase
        alu_zero = |alu_out;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge of the idle cycle after done.
    task automatic do_mul(input logic [15:0] ta, input logic [15:0] tb_v, input bit poke);
        drive_t      q[$];
        drive_t      e;
        logic [15:0] acc_m;
        logic [15:0] exp_prod;
        int          k;
        int          exp_lat;
        int          cycles;
        bit          done_seen;

        // Expected ALU traffic: per multiplier bit up to the highest set one, a bit test,
        // an addition of the shifted multiplicand if the bit is set, then an idle shift.
        k = 1;
        for (int i = 0; i < 16; i++) if (tb_v[i]) k = i + 1;
        acc_m = '0;
        for (int i = 0; i < k; i++) begin
            q.push_back('{ALU_AND, tb_v >> i, 16'd1});
            if (tb_v[i]) begin
                q.push_back('{ALU_ADD, acc_m, ta << i});
                acc_m = acc_m + (ta << i);
            end
            q.push_back('{ALU_ADD, 16'd0, 16'd0});
        end
        q.push_back('{ALU_ADD, 16'd0, 16'd0});
        exp_lat  = q.size() + 1;
        exp_prod = ta * tb_v;

        a = ta;
        b = tb_v;
        start = 1'b1;
        check("idle_before_start", busy, 0);
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        done_seen = 0;
        while (cycles < 200 && !done_seen) begin
            cycles++;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("alu_drive", {alu_op, alu_a, alu_b}, {e.op, e.x, e.y});
            end else begin
                check("alu_overrun", 0, 1);
            end
            check("busy_high", busy, 1);
            if (done) begin
                done_seen = 1;
            end else begin
                check("product_held", product, prev_product);
                if (poke) start = 1'($urandom);
                a = 16'($urandom);
                b = 16'($urandom);
                @(negedge clk);
            end
        end
        check("done_timeout", done_seen, 1);
        check("latency", cycles, exp_lat);
        start = poke;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("product", product, exp_prod);
        prev_product = exp_prod;
        start = 1'b0;
    endtask

    initial begin
        bit seen;

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort a long operation with reset: everything clears at once, no done follows.
        a = 16'h1234;
        b = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        check("abort_alu_op", alu_op, ALU_ADD);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("no_done_after_abort", seen, 0);
        prev_product = '0;

        do_mul(16'd5,    16'd1,    0);
        do_mul(16'h1234, 16'h0000, 0);
        do_mul(16'h00FF, 16'h0101, 0);
        do_mul(16'hFFFF, 16'hFFFF, 1);
        do_mul(16'h0000, 16'hA5A5, 1);
        do_mul(16'h8001, 16'h8000, 0);
        for (int n = 0; n < 25; n++)
            do_mul(16'($urandom), 16'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
